// File: rtl/bra_pre_sel_upd.sv
`default_nettype none
// ============================================================================
// Module      : bra_pre_sel_upd
// Description : Branch-predictor selector update engine. Resolved-branch
//               outcomes are filtered and queued, then applied to the
//               selection table as read-modify-write saturating-counter
//               updates on a single shared table port. Fetch lookups own the
//               port whenever they are active; updates stall around them.
// Revision    : 1.0 - initial release
// ============================================================================
module bra_pre_sel_upd #(
    parameter int DATA_W = 2,
    parameter int ADDR_W = 10,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pred_req,
    input  logic [ADDR_W-1:0] pred_addr,
    output logic              pred_use_global,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic              upd_gl_ok,
    input  logic              upd_lc_ok,
    output logic [ADDR_W-1:0] tab_addr,
    input  logic [DATA_W-1:0] tab_rd_data,
    output logic              tab_wr_en,
    output logic [DATA_W-1:0] tab_wr_data,
    output logic              busy,
    output logic [15:0]       wr_cnt
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_q_addr [QDEPTH];
    logic              r_q_dir  [QDEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic [ADDR_W-1:0] r_lat_addr;
    logic [DATA_W-1:0] r_lat_data;
    logic              r_lat_dir;
    logic [DATA_W-1:0] w_new_val;
    logic              w_push;
    logic              w_pop;

    // Updates where both predictors agree carry no selection information:
    // they complete the handshake but never enter the queue.
    assign upd_ready = (r_count < CNT_W'(QDEPTH));
    assign w_push    = upd_valid && upd_ready && !reset && (upd_gl_ok != upd_lc_ok);
    assign w_pop     = (r_state == ST_RD) && !pred_req && !reset && (r_count != '0);

    // Queue occupancy after this cycle's push/pop
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(QDEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(QDEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Queue storage; dir=1 means the global predictor won (increment)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr] <= upd_addr;
            r_q_dir[r_wr_ptr]  <= upd_gl_ok;
        end
    end

    // RMW sequencer: read the head entry in RD, write it back in WR
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_lat_addr <= '0;
            r_lat_data <= '0;
            r_lat_dir  <= 1'b0;
            wr_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_count != '0) begin
                        r_state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (w_pop) begin
                        r_lat_addr <= r_q_addr[r_rd_ptr];
                        r_lat_data <= tab_rd_data;
                        r_lat_dir  <= r_q_dir[r_rd_ptr];
                        r_state    <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (!pred_req) begin
                        if (wr_cnt != 16'hFFFF) begin
                            wr_cnt <= wr_cnt + 16'd1;
                        end
                        r_state <= (w_count_next != '0) ? ST_RD : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Saturating counter step; a saturated counter is rewritten unchanged
    always_comb begin
        w_new_val = r_lat_data;
        if (r_lat_dir) begin
            if (r_lat_data != {DATA_W{1'b1}}) begin
                w_new_val = r_lat_data + DATA_W'(1);
            end
        end else begin
            if (r_lat_data != '0) begin
                w_new_val = r_lat_data - DATA_W'(1);
            end
        end
    end

    // Table port arbitration: fetch lookups always win the address
    always_comb begin
        tab_addr = pred_addr;
        if (!pred_req) begin
            case (r_state)
                ST_RD:   tab_addr = r_q_addr[r_rd_ptr];
                ST_WR:   tab_addr = r_lat_addr;
                default: tab_addr = pred_addr;
            endcase
        end
    end

    assign tab_wr_en       = (r_state == ST_WR) && !pred_req && !reset;
    assign tab_wr_data     = tab_wr_en ? w_new_val : '0;
    assign busy            = (r_count != '0) || (r_state != ST_IDLE);
    assign pred_use_global = tab_rd_data[DATA_W-1];

endmodule
`default_nettype wire
